// File: rtl/fauxfs_wb_dma.sv
// fauxfs_wb_dma: Wishbone burst initiator copying len_i 32-bit words from
// src_adr_i to dst_adr_i through a BURST_LEN-deep staging buffer, using
// alternating incrementing read and write bursts.
// Ports:
//   wb_clk_i, wb_rst_n_i        clock, async active-low reset
//   start_i, src_adr_i,
//   dst_adr_i, len_i            command (sampled in IDLE only)
//   busy_o, done_o, error_o     status; done_o is a one-cycle pulse
//   wbm_*                       Wishbone master (cyc/stb/adr/dat/sel/we/cti/bte,
//                               ack/err/rty/dat_i)
module fauxfs_wb_dma #(
    parameter int unsigned BURST_LEN = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        start_i,
    input  logic [31:0] src_adr_i,
    input  logic [31:0] dst_adr_i,
    input  logic [9:0]  len_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic [2:0]  wbm_cti_o,
    output logic [1:0]  wbm_bte_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic        wbm_rty_i
);

    localparam int unsigned ADR_W = 32;
    localparam int unsigned LEN_W = 10;
    localparam int unsigned CNT_W = 5;
    localparam int unsigned IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0] CTI_NONE = 3'b000;
    localparam logic [2:0] CTI_INC  = 3'b010;
    localparam logic [2:0] CTI_END  = 3'b111;

    localparam logic [ADR_W-1:0] ADR_STEP = ADR_W'(4);
    localparam logic [ADR_W-1:0] ADR_MASK = ~ADR_W'(3);

    logic [1:0]       r_state, w_state_nxt;
    logic [ADR_W-1:0] r_src,   w_src_nxt;
    logic [ADR_W-1:0] r_dst,   w_dst_nxt;
    logic [LEN_W-1:0] r_rem,   w_rem_nxt;
    logic [CNT_W-1:0] r_n,     w_n_nxt;
    logic [CNT_W-1:0] r_k,     w_k_nxt;
    logic             r_cyc,   w_cyc_nxt;
    logic             r_we,    w_we_nxt;
    logic [3:0]       r_sel,   w_sel_nxt;
    logic [ADR_W-1:0] r_adr,   w_adr_nxt;
    logic [31:0]      r_dat,   w_dat_nxt;
    logic [2:0]       r_cti,   w_cti_nxt;
    logic             r_busy,  w_busy_nxt;
    logic             r_done,  w_done_nxt;
    logic             r_err,   w_err_nxt;

    logic [31:0]      r_buf [BURST_LEN];
    logic             w_buf_we;

    logic [CNT_W-1:0] w_k_inc;
    logic             w_last;
    logic [2:0]       w_cti_follow;
    logic [CNT_W-1:0] w_n_len;
    logic [CNT_W-1:0] w_n_rem;
    logic             w_ack;
    logic             w_term;

    // State and registered outputs
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state <= S_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_rem   <= '0;
            r_n     <= '0;
            r_k     <= '0;
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_sel   <= 4'h0;
            r_adr   <= '0;
            r_dat   <= '0;
            r_cti   <= CTI_NONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_src   <= w_src_nxt;
            r_dst   <= w_dst_nxt;
            r_rem   <= w_rem_nxt;
            r_n     <= w_n_nxt;
            r_k     <= w_k_nxt;
            r_cyc   <= w_cyc_nxt;
            r_we    <= w_we_nxt;
            r_sel   <= w_sel_nxt;
            r_adr   <= w_adr_nxt;
            r_dat   <= w_dat_nxt;
            r_cti   <= w_cti_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Staging buffer: pure storage, contents are don't-care after reset
    always_ff @(posedge wb_clk_i) begin
        if (w_buf_we) begin
            r_buf[r_k[IDX_W-1:0]] <= wbm_dat_i;
        end
    end

    // Next-state and output decode
    always_comb begin
        w_state_nxt = r_state;
        w_src_nxt   = r_src;
        w_dst_nxt   = r_dst;
        w_rem_nxt   = r_rem;
        w_n_nxt     = r_n;
        w_k_nxt     = r_k;
        w_cyc_nxt   = r_cyc;
        w_we_nxt    = r_we;
        w_adr_nxt   = r_adr;
        w_dat_nxt   = r_dat;
        w_cti_nxt   = r_cti;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_err_nxt   = r_err;
        w_buf_we    = 1'b0;

        w_k_inc      = r_k + CNT_W'(1);
        w_last       = (w_k_inc == r_n);
        w_cti_follow = ((r_k + CNT_W'(2)) == r_n) ? CTI_END : CTI_INC;
        w_n_len      = (len_i >= LEN_W'(BURST_LEN)) ? CNT_W'(BURST_LEN) : CNT_W'(len_i);
        w_n_rem      = (r_rem >= LEN_W'(BURST_LEN)) ? CNT_W'(BURST_LEN) : CNT_W'(r_rem);
        w_ack        = r_cyc & wbm_ack_i;
        w_term       = r_cyc & (wbm_err_i | wbm_rty_i);

        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_busy_nxt = 1'b1;
                    w_err_nxt  = 1'b0;
                    if (len_i != '0) begin
                        w_src_nxt   = src_adr_i & ADR_MASK;
                        w_dst_nxt   = dst_adr_i & ADR_MASK;
                        w_rem_nxt   = len_i;
                        w_n_nxt     = w_n_len;
                        w_k_nxt     = '0;
                        w_cyc_nxt   = 1'b1;
                        w_we_nxt    = 1'b0;
                        w_adr_nxt   = src_adr_i & ADR_MASK;
                        w_cti_nxt   = (w_n_len == CNT_W'(1)) ? CTI_END : CTI_INC;
                        w_state_nxt = S_RD;
                    end else begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_DONE;
                    end
                end
            end
            // cyc low in RD/WR is the one-cycle gap after a burst
            S_RD, S_WR: begin
                if (w_term) begin
                    w_cyc_nxt   = 1'b0;
                    w_we_nxt    = 1'b0;
                    w_cti_nxt   = CTI_NONE;
                    w_done_nxt  = 1'b1;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (w_ack) begin
                    w_k_nxt = w_k_inc;
                    if (r_state == S_RD) begin
                        w_buf_we  = 1'b1;
                        w_src_nxt = r_src + ADR_STEP;
                        w_adr_nxt = r_src + ADR_STEP;
                    end else begin
                        w_dst_nxt = r_dst + ADR_STEP;
                        w_adr_nxt = r_dst + ADR_STEP;
                        w_dat_nxt = r_buf[w_k_inc[IDX_W-1:0]];
                    end
                    if (w_last) begin
                        w_cyc_nxt = 1'b0;
                        w_we_nxt  = 1'b0;
                        w_cti_nxt = CTI_NONE;
                        if (r_state == S_WR) begin
                            w_rem_nxt = r_rem - LEN_W'(r_n);
                        end
                    end else begin
                        w_cti_nxt = w_cti_follow;
                    end
                end else if (!r_cyc) begin
                    if (r_state == S_RD) begin
                        w_k_nxt     = '0;
                        w_cyc_nxt   = 1'b1;
                        w_we_nxt    = 1'b1;
                        w_adr_nxt   = r_dst;
                        w_dat_nxt   = r_buf[0];
                        w_cti_nxt   = (r_n == CNT_W'(1)) ? CTI_END : CTI_INC;
                        w_state_nxt = S_WR;
                    end else if (r_rem != '0) begin
                        w_n_nxt     = w_n_rem;
                        w_k_nxt     = '0;
                        w_cyc_nxt   = 1'b1;
                        w_we_nxt    = 1'b0;
                        w_adr_nxt   = r_src;
                        w_cti_nxt   = (w_n_rem == CNT_W'(1)) ? CTI_END : CTI_INC;
                        w_state_nxt = S_RD;
                    end else begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_busy_nxt  = 1'b0;
                w_err_nxt   = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_sel_nxt = w_cyc_nxt ? 4'hf : 4'h0;
    end

    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign error_o   = r_err;
    assign wbm_adr_o = r_adr;
    assign wbm_dat_o = r_dat;
    assign wbm_sel_o = r_sel;
    assign wbm_we_o  = r_we;
    assign wbm_cti_o = r_cti;
    assign wbm_bte_o = 2'b00;
    assign wbm_cyc_o = r_cyc;
    assign wbm_stb_o = r_cyc;

endmodule

// File: tb/tb_fauxfs_wb_dma.sv
// Directed bench for fauxfs_wb_dma with a behavioural Wishbone slave.
// Reads return ((adr - rd_base) >> 2) ^ rd_key; writes land in mem[adr[11:2]].
module tb_fauxfs_wb_dma;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] src;
    logic [31:0] dst;
    logic [9:0]  len;
    logic        busy, done, err_o;
    logic [31:0] adr, dat_o, dat_i;
    logic [3:0]  sel;
    logic        we, cyc, stb;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        s_ack, s_err, s_rty;

    fauxfs_wb_dma #(.BURST_LEN(8)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .start_i    (start),
        .src_adr_i  (src),
        .dst_adr_i  (dst),
        .len_i      (len),
        .busy_o     (busy),
        .done_o     (done),
        .error_o    (err_o),
        .wbm_adr_o  (adr),
        .wbm_dat_o  (dat_o),
        .wbm_sel_o  (sel),
        .wbm_we_o   (we),
        .wbm_cti_o  (cti),
        .wbm_bte_o  (bte),
        .wbm_cyc_o  (cyc),
        .wbm_stb_o  (stb),
        .wbm_dat_i  (dat_i),
        .wbm_ack_i  (s_ack),
        .wbm_err_i  (s_err),
        .wbm_rty_i  (s_rty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave model
    logic [31:0] mem [1024];
    logic [31:0] rd_base, rd_key;
    int          wait_cfg, err_at;
    int          wait_cnt, beat_cnt;

    assign s_rty = 1'b0;
    assign dat_i = ((adr - rd_base) >> 2) ^ rd_key;

    always_comb begin
        s_ack = 1'b0;
        s_err = 1'b0;
        if (cyc && stb) begin
            if (err_at >= 0 && beat_cnt == err_at) s_err = 1'b1;
            else if (wait_cnt >= wait_cfg) s_ack = 1'b1;
        end
    end

    always @(posedge clk) begin
        if (cyc && stb && !s_ack && !s_err) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
        if (!cyc) beat_cnt <= 0;
        else if (s_ack) beat_cnt <= beat_cnt + 1;
        if (cyc && stb && s_ack && we) mem[adr[11:2]] <= dat_o;
    end

    // Bus monitor: beat log and protocol sanity
    logic [31:0] rd_adr_q[$], wr_adr_q[$], wr_dat_q[$];
    logic [2:0]  rd_cti_q[$], wr_cti_q[$];
    int          cyc_rises, done_cnt, viol;
    logic        prev_cyc, prev_hold, p_we;
    logic [31:0] p_adr, p_dat;
    logic [2:0]  p_cti;

    initial begin
        cyc_rises = 0; done_cnt = 0; viol = 0;
        prev_cyc = 1'b0; prev_hold = 1'b0;
        wait_cnt = 0; beat_cnt = 0;
    end

    always @(negedge clk) begin
        if (cyc && stb && s_ack) begin
            if (we) begin
                wr_adr_q.push_back(adr); wr_cti_q.push_back(cti); wr_dat_q.push_back(dat_o);
            end else begin
                rd_adr_q.push_back(adr); rd_cti_q.push_back(cti);
            end
        end
        if (cyc && !prev_cyc) cyc_rises = cyc_rises + 1;
        if (done) done_cnt = done_cnt + 1;
        if (cyc != stb) viol = viol + 1;
        if (sel != (stb ? 4'hf : 4'h0)) viol = viol + 1;
        if (bte != 2'b00 || adr[1:0] != 2'b00) viol = viol + 1;
        if (stb && prev_hold &&
            (adr != p_adr || cti != p_cti || we != p_we || (we && dat_o != p_dat)))
            viol = viol + 1;
        prev_hold = stb && !s_ack && !s_err;
        prev_cyc  = cyc;
        p_adr = adr; p_cti = cti; p_we = we; p_dat = dat_o;
    end

    int n_checks, n_errors;
    int r0, w0, c0, d0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic snap();
        r0 = rd_adr_q.size(); w0 = wr_adr_q.size();
        c0 = cyc_rises;       d0 = done_cnt;
    endtask

    // Drive a start strobe; returns #1 after the accepting edge
    task automatic start_xfer(input logic [31:0] s, input logic [31:0] d, input logic [9:0] l);
        @(negedge clk);
        start = 1'b1; src = s; dst = d; len = l;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Cycle index 1 is the first cycle after the accepting edge; -1 on timeout
    task automatic wait_done(input int budget, output int idx, output logic e);
        idx = -1; e = 1'b0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (done) begin idx = i; e = err_o; break; end
        end
    endtask

    int   idx;
    logic e;

    initial begin
        n_checks = 0; n_errors = 0;
        rst_n = 1'b0; start = 1'b0; src = '0; dst = '0; len = '0;
        wait_cfg = 0; err_at = -1; rd_base = '0; rd_key = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cyc",  {31'd0, cyc},  32'd0);
        check("rst_stb",  {31'd0, stb},  32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err",  {31'd0, err_o}, 32'd0);
        check("rst_adr",  adr, 32'd0);
        check("rst_dat",  dat_o, 32'd0);
        check("rst_cti",  {29'd0, cti}, 32'd0);
        check("rst_sel",  {28'd0, sel}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single 8-word burst pair, zero-wait slave
        rd_base = 32'h0010_5800; rd_key = 32'h1111_0000; snap();
        start_xfer(32'h0010_5800, 32'h0010_5000, 10'd8);
        check("t1_busy_t1", {31'd0, busy}, 32'd1);
        check("t1_cyc_t1",  {31'd0, cyc},  32'd1);
        check("t1_adr_t1",  adr, 32'h0010_5800);
        wait_done(200, idx, e);
        check("t1_done_cycle", 32'(idx), 32'd19);
        check("t1_error", {31'd0, e}, 32'd0);
        check("t1_rd_beats", 32'(rd_adr_q.size() - r0), 32'd8);
        check("t1_wr_beats", 32'(wr_adr_q.size() - w0), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check("t1_rd_cti", {29'd0, rd_cti_q[r0+i]}, (i == 7) ? 32'd7 : 32'd2);
            check("t1_wr_cti", {29'd0, wr_cti_q[w0+i]}, (i == 7) ? 32'd7 : 32'd2);
            check("t1_wr_dat", wr_dat_q[w0+i], 32'(i) ^ 32'h1111_0000);
            check("t1_wr_adr", wr_adr_q[w0+i], 32'h0010_5000 + 32'(4*i));
        end

        // 20 words: bursts of 8, 8, 4
        rd_base = 32'h0000_1000; rd_key = 32'h0; snap();
        start_xfer(32'h0000_1000, 32'h0000_1800, 10'd20);
        wait_done(400, idx, e);
        check("t2_done_cycle", 32'(idx), 32'd47);
        check("t2_cyc_bursts", 32'(cyc_rises - c0), 32'd6);
        check("t2_wr_beats", 32'(wr_adr_q.size() - w0), 32'd20);
        for (int i = 0; i < 20; i++) begin
            check("t2_dst_mem", mem[10'(32'h200 + 32'(i))], 32'(i));
            check("t2_wr_adr", wr_adr_q[w0+i], 32'h0000_1800 + 32'(4*i));
            check("t2_rd_cti", {29'd0, rd_cti_q[r0+i]},
                  (i == 7 || i == 15 || i == 19) ? 32'd7 : 32'd2);
        end

        // Two wait states per beat
        wait_cfg = 2; rd_base = 32'h0000_0b00; rd_key = 32'h3333_0000; snap();
        start_xfer(32'h0000_0b00, 32'h0000_0c00, 10'd3);
        wait_done(200, idx, e);
        check("t3_done_cycle", 32'(idx), 32'd21);
        check("t3_beats", 32'(rd_adr_q.size() - r0 + wr_adr_q.size() - w0), 32'd6);
        for (int i = 0; i < 3; i++)
            check("t3_dst_mem", mem[10'(32'h300 + 32'(i))], 32'(i) ^ 32'h3333_0000);
        check("t3_hold_viol", 32'(viol), 32'd0);
        wait_cfg = 0;

        // Error on the third read beat
        err_at = 2; rd_base = 32'h0000_0900; rd_key = 32'h4444_0000; snap();
        start_xfer(32'h0000_0900, 32'h0000_0a00, 10'd8);
        wait_done(200, idx, e);
        check("t4_done_cycle", 32'(idx), 32'd4);
        check("t4_error", {31'd0, e}, 32'd1);
        check("t4_cyc_low", {31'd0, cyc}, 32'd0);
        check("t4_rd_beats", 32'(rd_adr_q.size() - r0), 32'd2);
        check("t4_wr_beats", 32'(wr_adr_q.size() - w0), 32'd0);
        check("t4_cyc_bursts", 32'(cyc_rises - c0), 32'd1);
        err_at = -1;
        @(negedge clk);
        check("t4_err_clear", {31'd0, err_o}, 32'd0);

        // Zero length
        snap();
        start_xfer(32'h0000_0100, 32'h0000_0200, 10'd0);
        check("t5_busy_t1", {31'd0, busy}, 32'd1);
        check("t5_done_t1", {31'd0, done}, 32'd1);
        wait_done(10, idx, e);
        check("t5_done_cycle", 32'(idx), 32'd1);
        check("t5_error", {31'd0, e}, 32'd0);
        @(negedge clk);
        check("t5_busy_after", {31'd0, busy}, 32'd0);
        check("t5_no_cyc", 32'(cyc_rises - c0), 32'd0);

        // Start while busy is ignored
        rd_base = 32'h0000_2000; rd_key = 32'h5555_0000; snap();
        start_xfer(32'h0000_2000, 32'h0000_3000, 10'd4);
        start_xfer(32'h0000_4000, 32'h0000_5000, 10'd2);
        wait_done(200, idx, e);
        check("t5b_done_seen", {31'd0, (idx > 0)}, 32'd1);
        repeat (15) @(negedge clk);
        check("t5b_done_count", 32'(done_cnt - d0), 32'd1);
        check("t5b_rd_beats", 32'(rd_adr_q.size() - r0), 32'd4);
        check("t5b_cyc_bursts", 32'(cyc_rises - c0), 32'd2);
        check("t5b_wr_adr0", wr_adr_q[w0], 32'h0000_3000);

        // Source address wraps past the top of the address space
        rd_base = 32'hffff_fff8; rd_key = 32'h6060_0000; snap();
        start_xfer(32'hffff_fff8, 32'h0000_0100, 10'd3);
        wait_done(200, idx, e);
        check("t7_wrap_adr", rd_adr_q[r0+2], 32'h0000_0000);
        for (int i = 0; i < 3; i++)
            check("t7_dst_mem", mem[10'(32'h40 + 32'(i))], 32'(i) ^ 32'h6060_0000);

        // Reset during write beat 2
        rd_base = 32'h0000_0500; rd_key = 32'h6666_0000; snap();
        start_xfer(32'h0000_0500, 32'h0000_0600, 10'd4);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (wr_adr_q.size() - w0 >= 1) break;
        end
        check("t6_reached_wr", 32'(wr_adr_q.size() - w0), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_cyc",  {31'd0, cyc},  32'd0);
        check("t6_rst_stb",  {31'd0, stb},  32'd0);
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd_base = 32'h0000_0700; rd_key = 32'h7777_0000; snap();
        start_xfer(32'h0000_0700, 32'h0000_0800, 10'd1);
        wait_done(50, idx, e);
        check("t6_done_cycle", 32'(idx), 32'd5);
        check("t6_rd_beats", 32'(rd_adr_q.size() - r0), 32'd1);
        check("t6_wr_beats", 32'(wr_adr_q.size() - w0), 32'd1);
        check("t6_rd_cti", {29'd0, rd_cti_q[r0]}, 32'd7);
        check("t6_wr_cti", {29'd0, wr_cti_q[w0]}, 32'd7);
        check("t6_wr_dat", wr_dat_q[w0], 32'h7777_0000);

        check("protocol_viol", 32'(viol), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
